// File: rtl/arith_pkg.sv
// Shared definitions for the 4-bit arithmetic unit and the controllers that drive it.
// The unit's bit order runs opposite to the controller's: rev4 converts between the two.
package arith_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ADD  = 2'b00;
    localparam logic [1:0] SEL_SUB  = 2'b01;
    localparam logic [1:0] SEL_PASS = 2'b10;
    localparam logic [1:0] SEL_DEC  = 2'b11;

    function automatic logic [ALU_W-1:0] rev4(input logic [ALU_W-1:0] x);
        logic [ALU_W-1:0] r;
        for (int i = 0; i < ALU_W; i++) begin
            r[i] = x[ALU_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add 4x4 unsigned multiplier controller wrapped around an external
// 4-bit arithmetic unit; one add and one shift per multiplier bit.
module mult_seq_ctrl
    import arith_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [ALU_W-1:0] MCAND,
    input  logic [ALU_W-1:0] MPLIER,
    output logic             SEL0,
    output logic             SEL1,
    output logic [ALU_W-1:0] ALU_A,
    output logic [ALU_W-1:0] ALU_B,
    output logic             ALU_CIN,
    input  logic [ALU_W-1:0] ALU_D,
    input  logic             ALU_COUT,
    output logic [7:0]       PRODUCT,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state_q, state_d;
    logic [ALU_W-1:0] m_q, m_d;
    logic [ALU_W-1:0] acc_q, acc_d;
    logic [ALU_W-1:0] q_q, q_d;
    logic             c_q, c_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       product_q, product_d;

    logic [1:0]       sel;
    logic [8:0]       shift_v;
    logic             start_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sel       = SEL_PASS;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_CIN   = 1'b0;
        shift_v   = {c_q, acc_q, q_q} >> 1;
        start_ok  = START && (state_q == ST_IDLE || state_q == ST_DONE);

        case (state_q)
            ST_IDLE: ;
            ST_ADD: begin
                ALU_A = rev4(acc_q);
                ALU_B = rev4(m_q);
                // A zero multiplier bit passes acc through unchanged instead of adding.
                sel   = q_q[0] ? SEL_ADD : SEL_PASS;
                c_d   = ALU_COUT;
                acc_d = rev4(ALU_D);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                c_d   = shift_v[8];
                acc_d = shift_v[7:4];
                q_d   = shift_v[3:0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = shift_v[7:0];
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_ADD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            m_d     = MCAND;
            q_d     = MPLIER;
            acc_d   = '0;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = ST_ADD;
        end
    end

    assign SEL1    = sel[1];
    assign SEL0    = sel[0];
    assign PRODUCT = product_q;
    assign BUSY    = (state_q == ST_ADD) || (state_q == ST_SHIFT);
    assign DONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a behavioural ALU closes the loop, the stimulus
// queues expected operations, and a monitor checks every cycle against that queue.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [3:0] MCAND = '0;
    logic [3:0] MPLIER = '0;
    logic       SEL0, SEL1, ALU_CIN, ALU_COUT, BUSY, DONE;
    logic [3:0] ALU_A, ALU_B, ALU_D;
    logic [7:0] PRODUCT;

    mult_seq_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .MCAND(MCAND), .MPLIER(MPLIER),
        .SEL0(SEL0), .SEL1(SEL1), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
        .ALU_D(ALU_D), .ALU_COUT(ALU_COUT), .PRODUCT(PRODUCT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] flip(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Behavioural arithmetic unit: bit 3 is the LSB end on every bus.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case ({SEL1, SEL0})
            2'b00: alu_sum = {1'b0, flip(ALU_A)} + {1'b0, flip(ALU_B)} + {4'b0, ALU_CIN};
            2'b01: alu_sum = {1'b0, flip(ALU_A)} + {1'b0, ~flip(ALU_B)} + {4'b0, ALU_CIN};
            2'b10: alu_sum = {1'b0, flip(ALU_A)} + {4'b0, ALU_CIN};
            default: alu_sum = {1'b0, flip(ALU_A)} + 5'h0F + {4'b0, ALU_CIN};
        endcase
    end
    assign ALU_D    = flip(alu_sum[3:0]);
    assign ALU_COUT = alu_sum[4];

    typedef struct {
        logic [3:0] mc;
        logic [3:0] mp;
        int         k;
        logic [7:0] prod;
    } op_t;

    op_t  sb[$];
    int   cyc = 0;
    logic rst_s = 1'b1;
    int   last_acc = -100;
    logic [7:0] last_prod = '0;
    logic cout_seen = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_s <= RST;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle_bus();
        chk("idle_sel",  {30'b0, SEL1, SEL0}, 32'd2);
        chk("idle_alu_a", {28'b0, ALU_A}, 32'd0);
        chk("idle_alu_b", {28'b0, ALU_B}, 32'd0);
        chk("idle_cin",  {31'b0, ALU_CIN}, 32'd0);
    endtask

    // Monitor: compares the DUT against the front of the scoreboard each cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (rst_s) begin
                sb.delete();
                last_prod = '0;
                chk("rst_product", {24'b0, PRODUCT}, 32'd0);
                chk("rst_busy", {31'b0, BUSY}, 32'd0);
                chk("rst_done", {31'b0, DONE}, 32'd0);
                chk_idle_bus();
            end else if (sb.size() > 0) begin
                op_t e;
                int  d;
                e = sb[0];
                d = cyc - e.k;
                chk("busy", {31'b0, BUSY}, {31'b0, (d < 8)});
                chk("done", {31'b0, DONE}, {31'b0, (d == 8)});
                if (d < 8 && d % 2 == 0) begin
                    int j;
                    int part;
                    j    = d / 2;
                    part = (int'(e.mc) * (int'(e.mp) & ((1 << j) - 1))) >> j;
                    chk("add_sel", {30'b0, SEL1, SEL0}, e.mp[j] ? 32'd0 : 32'd2);
                    chk("add_alu_b", {28'b0, ALU_B}, {28'b0, flip(e.mc)});
                    chk("add_alu_a", {28'b0, ALU_A}, {28'b0, flip(part[3:0])});
                    chk("add_cin", {31'b0, ALU_CIN}, 32'd0);
                    if (ALU_COUT) cout_seen = 1'b1;
                end
                if (d >= 8) begin
                    chk("product", {24'b0, PRODUCT}, {24'b0, e.prod});
                    $display("op %0d x %0d: PRODUCT=%0d expected %0d at cycle %0d",
                             e.mc, e.mp, PRODUCT, e.prod, cyc);
                    last_prod = e.prod;
                    void'(sb.pop_front());
                end else begin
                    chk("product_hold", {24'b0, PRODUCT}, {24'b0, last_prod});
                end
            end else begin
                chk("idle_busy", {31'b0, BUSY}, 32'd0);
                chk("idle_done", {31'b0, DONE}, 32'd0);
                chk("idle_product", {24'b0, PRODUCT}, {24'b0, last_prod});
                chk_idle_bus();
            end
        end
    end

    // Hold START for ncyc edges; each edge where the DUT can accept becomes an operation.
    task automatic run_start(input logic [3:0] mc, input logic [3:0] mp, input int ncyc);
        @(negedge CLK);
        START  = 1'b1;
        MCAND  = mc;
        MPLIER = mp;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge CLK);
            #1;
            if (cyc >= last_acc + 9) begin
                op_t e;
                e.mc   = mc;
                e.mp   = mp;
                e.k    = cyc;
                e.prod = {4'b0, mc} * {4'b0, mp};
                sb.push_back(e);
                last_acc = cyc;
            end
        end
        START = 1'b0;
    endtask

    task automatic wait_free();
        @(negedge CLK);
        while (cyc + 1 < last_acc + 9) @(negedge CLK);
    endtask

    task automatic apply_reset(input int n);
        @(negedge CLK);
        RST = 1'b1;
        last_acc = -100;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(3);
        repeat (5) @(negedge CLK);

        wait_free(); run_start(4'd3, 4'd5, 1);
        wait_free();
        cout_seen = 1'b0;
        run_start(4'd15, 4'd15, 1);
        wait_free(); repeat (2) @(negedge CLK);
        chk("cout_seen_15x15", {31'b0, cout_seen}, 32'd1);

        wait_free(); run_start(4'd9, 4'd0, 1);
        wait_free(); run_start(4'd0, 4'd7, 1);

        wait_free(); run_start(4'd6, 4'd7, 1);
        repeat (2) @(negedge CLK);
        run_start(4'd1, 4'd1, 1);

        wait_free(); repeat (2) @(negedge CLK);
        run_start(4'd15, 4'd15, 1);
        repeat (3) @(negedge CLK);
        apply_reset(1);
        repeat (3) @(negedge CLK);

        run_start(4'd2, 4'd3, 10);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] mc, mp;
            mc = 4'($urandom_range(0, 15));
            mp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                run_start(mc, mp, $urandom_range(2, 12));
            end else begin
                wait_free();
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                run_start(mc, mp, 1);
            end
        end

        wait_free();
        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential 4x4 unsigned shift-and-add multiplier controller. It sits directly around `arithmetic_circuit`: it drives that unit's select, operand and carry-in lines, and captures its sum and carry-out each iteration. It accumulates the 8-bit product over four add/shift iterations and reports completion with a one-cycle DONE pulse. The integration wrapper `mult_unit` instantiates this block and one `arithmetic_circuit`.

## Interface
- No parameters; width fixed at 4 to match `arithmetic_circuit`.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request; sampled only in IDLE or DONE.
- MCAND  in  4  multiplicand, LSB at bit 0; captured on accepted START.
- MPLIER  in  4  multiplier, LSB at bit 0; captured on accepted START.
- SEL0, SEL1  out  1 each  ALU select.
- ALU_A  out  4  ALU operand A.
- ALU_B  out  4  ALU operand B.
- ALU_CIN  out  1  ALU carry-in.
- ALU_D  in  4  ALU sum.
- ALU_COUT  in  1  ALU carry-out.
- PRODUCT  out  8  result, LSB at bit 0.
- BUSY  out  1  high in ADD and SHIFT states.
- DONE  out  1  high for exactly the one cycle spent in the DONE state.

## Operation
- ALU bit order is fixed: ALU bit 3 is the carry-in (least significant) end and bit 0 is the carry-out end.
  - Controller drives ALU_A[3-i] = acc[i] and ALU_B[3-i] = m[i].
  - Controller reads sum bit i from ALU_D[3-i].
- ALU select codes (SEL1,SEL0):
  - 00 add B
  - 01 add ~B
  - 10 pass A (B = 0)
  - 11 add all-ones
  - This block uses only 00 and 10.
- Registers:
  - m[3:0] multiplicand
  - acc[3:0] high product half
  - q[3:0] multiplier / low half
  - c carry
  - cnt[1:0] iteration count
- States: IDLE, ADD, SHIFT, DONE.
  - IDLE: outputs SEL=10, ALU_A=ALU_B=0, ALU_CIN=0. On START: m<=MCAND, q<=MPLIER, acc<=0, c<=0, cnt<=0; go to ADD.
  - ADD: ALU_A=acc, ALU_B=m (bit-reversed as above), ALU_CIN=0. SEL=00 if q[0]=1, else 10. Capture {c,acc} <= {ALU_COUT, sum}; go to SHIFT.
  - SHIFT: {c,acc,q} <= {1'b0,c,acc,q} >> 1, a 9-bit logical right shift. cnt<=cnt+1. Go to ADD if cnt != 3, else go to DONE.
  - DONE: PRODUCT <= {acc,q} on entry, so it is visible during DONE. On START, reload as in IDLE and go to ADD; otherwise go to IDLE.
- In ADD, SHIFT and DONE, ALU outputs are combinational from state and registers only; there is no path from START to the ALU outputs.
- PRODUCT holds its value until the next completed operation; it is not cleared by a new START.
- START while BUSY is ignored; operands are not re-captured.
- Arithmetic is unsigned. c holds the 5th bit of each partial sum, so 15x15 is exact.

## Timing
- Reset (any state, including mid-operation): state IDLE; PRODUCT=0, BUSY=0, DONE=0; m, acc, q, c, cnt = 0; SEL=10, ALU_A=ALU_B=0, ALU_CIN=0. The in-flight result is discarded.
- START accepted at edge 0 gives:
  - ADD1 in cycle 1, SHIFT1 in cycle 2, ..., ADD4 in cycle 7, SHIFT4 in cycle 8.
  - DONE=1 and PRODUCT valid in cycle 9.
  - Latency is 9 cycles from accept edge to DONE.
- BUSY is high in cycles 1-8 and low in IDLE and DONE.
- Back-to-back: START high during DONE starts the next ADD1 in the next cycle. DONE pulses once per operation.
- Single-cycle ALU path: the ALU result is captured at the end of the same ADD cycle that drives the operands.

## Structure
- Shared package `arith_pkg` holds:
  - state encoding constants ST_IDLE, ST_ADD, ST_SHIFT, ST_DONE;
  - select constants SEL_ADD=2'b00, SEL_SUB=2'b01, SEL_PASS=2'b10, SEL_DEC=2'b11;
  - ALU width constant 4;
  - function `rev4` for ALU bit-order conversion.
- No sub-module inside `mult_seq_ctrl`.
- `mult_unit` wrapper is the only place it connects to `arithmetic_circuit`.

## Test plan
- Reset then idle: PRODUCT=8'h00, BUSY=0, DONE=0, SEL1/SEL0=1/0 held for 5 cycles.
- MCAND=3, MPLIER=5, START one cycle: BUSY cycles 1-8; DONE in cycle 9 only; PRODUCT=8'h0F. In ADD1, SEL=00 and ALU_B=4'b1100.
- MCAND=15, MPLIER=15: PRODUCT=8'hE1 (225); ALU_COUT=1 captured in at least one ADD cycle.
- MCAND=9, MPLIER=0: all ADD cycles show SEL=10; PRODUCT=8'h00. Then MCAND=0, MPLIER=7: PRODUCT=8'h00.
- MCAND=6, MPLIER=7, START re-pulsed with MCAND=1, MPLIER=1 in cycle 4: ignored; PRODUCT=8'h2A (42) in cycle 9.
- RST in cycle 5 of a 15x15 operation: next cycle IDLE, PRODUCT=0, no DONE. Then MCAND=2, MPLIER=3 with START held through DONE: first DONE PRODUCT=8'h06, second ADD1 starts the cycle after DONE.
